// File: rtl/alt_vipvfr131_common_stream_output_buf.sv
// rtl/alt_vipvfr131_common_stream_output_buf.sv - show-ahead FIFO output stage for Avalon-ST video with packet-boundary run gating
//
// Purpose:
//   Buffers an algorithmic core's internal stream in a DEPTH-entry show-ahead
//   FIFO and presents it on the dout port. Packet flow is gated by 'enable',
//   but a change of 'enable' is only applied between image packets, so a packet
//   in progress always completes and control packets that follow an image
//   travel with the next image packet.
//
// Optional feature (macro STREAM_OUTPUT_FRAME_COUNT_EN):
//   Defined   - frame_count counts popped eop beats of image packets (wraps at 16 bits).
//   Undefined - frame_count is tied to zero and no per-entry tag is stored.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   int_valid/ready    internal stream handshake (input side)
//   int_data/sop/eop   internal stream payload and packet delimiters
//   dout_valid/ready   output handshake, ready latency 0
//   dout_data/sop/eop  FIFO head payload
//   enable             requested run state
//   synced             requested run state fully applied
//   fifo_level         entries held, 0..DEPTH
//   frame_count        completed image packets (optional feature)

module alt_vipvfr131_common_stream_output_buf #(
  parameter int BITS_PER_SYMBOL  = 10,
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int FIFO_DEPTH_LOG2  = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      int_valid,
  output logic                                      int_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] int_data,
  input  logic                                      int_sop,
  input  logic                                      int_eop,
  output logic                                      dout_valid,
  input  logic                                      dout_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                      dout_sop,
  output logic                                      dout_eop,
  input  logic                                      enable,
  output logic                                      synced,
  output logic [FIFO_DEPTH_LOG2:0]                  fifo_level,
  output logic [15:0]                               frame_count
);

  localparam int DATA_WIDTH = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int LW         = FIFO_DEPTH_LOG2 + 1;

  // FIFO storage
  logic [DATA_WIDTH-1:0]      mem_data [DEPTH];
  logic                       mem_sop  [DEPTH];
  logic                       mem_eop  [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]              level;

  // Packet tracking and gating state
  logic in_packet;
  logic cur_image;
  logic boundary_reg;
  logic gate_reg;
  logic gate;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic beat_image;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Gate only follows 'enable' while parked on an image-packet boundary;
  // otherwise it holds its last value so the current packet run completes.
  assign gate      = boundary_reg ? enable : gate_reg;
  assign int_ready = gate && !full;
  assign synced    = (gate == enable) && (gate || empty);

  assign push = int_valid && int_ready;
  assign pop  = dout_valid && dout_ready;

  // A sop beat decides image-ness from its type nibble; later beats inherit it.
  // An eop arriving outside a packet is never treated as an image eop.
  assign beat_image = int_sop ? (int_data[3:0] == 4'd0) : (in_packet && cur_image);

  assign dout_valid = !empty;
  assign dout_data  = mem_data[rd_ptr];
  assign dout_sop   = mem_sop[rd_ptr];
  assign dout_eop   = mem_eop[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_sop[i]  <= 1'b0;
        mem_eop[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= int_data;
      mem_sop[wr_ptr]  <= int_sop;
      mem_eop[wr_ptr]  <= int_eop;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_packet    <= 1'b0;
      cur_image    <= 1'b0;
      boundary_reg <= 1'b1;
      gate_reg     <= 1'b0;
    end else begin
      gate_reg <= gate;
      if (push) begin
        if (int_sop) cur_image <= beat_image;
        // eop takes priority so a single-beat packet leaves in_packet clear
        if (int_eop)      in_packet <= 1'b0;
        else if (int_sop) in_packet <= 1'b1;
        // eop of an image wins over sop so a single-beat image ends on a boundary
        if (int_eop && beat_image) boundary_reg <= 1'b1;
        else if (int_sop)          boundary_reg <= 1'b0;
      end
    end
  end

`ifdef STREAM_OUTPUT_FRAME_COUNT_EN
  logic        mem_tag [DEPTH];
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_tag[i] <= 1'b0;
    end else if (push) begin
      mem_tag[wr_ptr] <= beat_image;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (pop && mem_eop[rd_ptr] && mem_tag[rd_ptr]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'd0;
`endif

endmodule
